// File: rtl/argmax_pipe_if.sv
// Sample/result bundle for argmax_pipe: one N*W-bit sample in, one arg-max result out.
// The producer/consumer side takes the master modport and the pipeline takes the slave modport.
interface argmax_pipe_if #(
    parameter int N = 3,
    parameter int W = 10
);
    localparam int IW = ($clog2(N) > 1) ? $clog2(N) : 1;

    logic            in_valid;
    logic [N*W-1:0]  in_data;
    logic            out_valid;
    logic [W-1:0]    out_value;
    logic [IW-1:0]   out_index;
    logic [W-1:0]    out_second;
    logic            out_dominant;

    modport master (
        output in_valid, in_data,
        input  out_valid, out_value, out_index, out_second, out_dominant
    );

    modport slave (
        input  in_valid, in_data,
        output out_valid, out_value, out_index, out_second, out_dominant
    );
endinterface

// File: rtl/argmax_pipe.sv
// Pipelined arg-max over N unsigned W-bit channels: a registered binary tournament tree,
// then a result stage that reports the winner, its runner-up and a dominance flag.
module argmax_pipe #(
    parameter int N             = 3,
    parameter int W             = 10,
    parameter int MARGIN        = 0,
    parameter int HOLD_ON_AMBIG = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ce,
    argmax_pipe_if.slave bus
);
    localparam int D  = $clog2(N);
    localparam int IW = (D > 1) ? D : 1;
    localparam int P  = 1 << D;

    // Pad leaves hold zero at indices >= N, so a real channel always wins a tie against them.
    logic [P*W-1:0]       padded;
    logic [P-1:0][W-1:0]  leaf_m;
    logic [P-1:0][IW-1:0] leaf_idx;

    always_comb begin
        padded          = '0;
        padded[N*W-1:0] = bus.in_data;
        for (int i = 0; i < P; i++) begin
            leaf_m[i]   = padded[i*W +: W];
            leaf_idx[i] = IW'(i);
        end
    end

    for (genvar l = 1; l <= D; l++) begin : g_lvl
        localparam int NN = P >> l;

        logic [2*NN-1:0][W-1:0]  a_m;
        logic [2*NN-1:0][W-1:0]  a_s;
        logic [2*NN-1:0][IW-1:0] a_idx;
        logic                    a_vld;

        logic [NN-1:0][W-1:0]    m_d, m_q;
        logic [NN-1:0][W-1:0]    s_d, s_q;
        logic [NN-1:0][IW-1:0]   idx_d, idx_q;
        logic                    vld_d, vld_q;

        if (l == 1) begin : g_src
            assign a_m   = leaf_m;
            assign a_s   = '0;
            assign a_idx = leaf_idx;
            assign a_vld = bus.in_valid;
        end else begin : g_src
            assign a_m   = g_lvl[l-1].m_q;
            assign a_s   = g_lvl[l-1].s_q;
            assign a_idx = g_lvl[l-1].idx_q;
            assign a_vld = g_lvl[l-1].vld_q;
        end

        // The runner-up of a pair is the larger of the winner's own runner-up and the loser's max.
        always_comb begin
            m_d   = '0;
            s_d   = '0;
            idx_d = '0;
            vld_d = a_vld;
            for (int j = 0; j < NN; j++) begin
                if (a_m[2*j] >= a_m[2*j+1]) begin
                    m_d[j]   = a_m[2*j];
                    idx_d[j] = a_idx[2*j];
                    s_d[j]   = (a_s[2*j] >= a_m[2*j+1]) ? a_s[2*j] : a_m[2*j+1];
                end else begin
                    m_d[j]   = a_m[2*j+1];
                    idx_d[j] = a_idx[2*j+1];
                    s_d[j]   = (a_m[2*j] >= a_s[2*j+1]) ? a_m[2*j] : a_s[2*j+1];
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                m_q   <= '0;
                s_q   <= '0;
                idx_q <= '0;
                vld_q <= 1'b0;
            end else if (ce) begin
                m_q   <= m_d;
                s_q   <= s_d;
                idx_q <= idx_d;
                vld_q <= vld_d;
            end
        end
    end

    logic [W-1:0]  top_m, top_s, diff;
    logic [IW-1:0] top_idx;
    logic          top_vld, dom;

    assign top_m   = g_lvl[D].m_q[0];
    assign top_s   = g_lvl[D].s_q[0];
    assign top_idx = g_lvl[D].idx_q[0];
    assign top_vld = g_lvl[D].vld_q;
    assign diff    = top_m - top_s;
    assign dom     = 64'(diff) > 64'(MARGIN);

    logic          out_valid_d, out_valid_q;
    logic [W-1:0]  out_value_d, out_value_q;
    logic [IW-1:0] out_index_d, out_index_q;
    logic [W-1:0]  out_second_d, out_second_q;
    logic          out_dominant_d, out_dominant_q;

    // With HOLD_ON_AMBIG set, value/index only move on a dominant result; bubbles hold everything.
    always_comb begin
        out_valid_d    = top_vld;
        out_value_d    = out_value_q;
        out_index_d    = out_index_q;
        out_second_d   = out_second_q;
        out_dominant_d = out_dominant_q;
        if (top_vld) begin
            out_second_d   = top_s;
            out_dominant_d = dom;
            if (HOLD_ON_AMBIG == 0 || dom) begin
                out_value_d = top_m;
                out_index_d = top_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q    <= 1'b0;
            out_value_q    <= '0;
            out_index_q    <= '0;
            out_second_q   <= '0;
            out_dominant_q <= 1'b0;
        end else if (ce) begin
            out_valid_q    <= out_valid_d;
            out_value_q    <= out_value_d;
            out_index_q    <= out_index_d;
            out_second_q   <= out_second_d;
            out_dominant_q <= out_dominant_d;
        end
    end

    assign bus.out_valid    = out_valid_q;
    assign bus.out_value    = out_value_q;
    assign bus.out_index    = out_index_q;
    assign bus.out_second   = out_second_q;
    assign bus.out_dominant = out_dominant_q;
endmodule

// File: doc/argmax_pipe.md
Name: argmax_pipe

Overview:
- Parametrised, pipelined arg-max over N unsigned channels of W bits (RGB skin-classifier default: N=3, W=10).
- Per accepted sample, reports maximum value, its channel index, the runner-up value and a dominance flag (winner exceeds runner-up by more than MARGIN).
- Fully pipelined, one sample per clock, with clock-enable stall.
- Sits between the colour-space/normalisation stage and the skin-decision logic.

Parameters:
- N, 3, number of channels (2..8).
- W, 10, channel width in bits.
- MARGIN, 0, dominance threshold: dominant when (max - second) > MARGIN.
- HOLD_ON_AMBIG, 1, 1 = out_value/out_index keep the last dominant result when the current sample is not dominant; 0 = always update.
- Derived (localparam, not overridable): IW = max(1, clog2(N)); D = clog2(N) tree levels; latency L = D+1.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ce  in  1  clock enable; low freezes the entire pipeline.
- in_valid  in  1  in_data holds a sample this cycle (sampled only when ce=1).
- in_data  in  N*W  channel i at bits [i*W +: W], unsigned.
- out_valid  out  1  outputs carry a new result this cycle.
- out_value  out  W  maximum value.
- out_index  out  IW  channel index of maximum.
- out_second  out  W  runner-up value (equal to max on a tie).
- out_dominant  out  1  (out_value_current - out_second) > MARGIN.

Behaviour:
- Reset (async assert, sync-safe deassert handled upstream): all pipeline registers and outputs cleared: out_valid=0, out_value=0, out_index=0, out_second=0, out_dominant=0. Reset mid-stream discards all in-flight samples; no partial result emerges after release.
- Leaves: channel i becomes node (m=x_i, idx=i, s=0). Pad to 2^D leaves with (m=0, idx=pad position, s=0); pads sit at indices >= N, so real channels win ties against them.
- Combine node a (lower indices) with b: if m_a >= m_b then m=m_a, idx=idx_a, s=max(s_a, m_b); else m=m_b, idx=idx_b, s=max(m_a, s_b). Ties go to the lower index.
- One register stage per tree level (D stages), valid bit travels alongside. A final stage computes diff = m - s in W bits (never negative, since m >= s), dominant = diff > MARGIN, and registers the outputs.
- Latency: a sample accepted at edge k (ce=1, in_valid=1) gives out_valid=1 after L enabled edges. N=3 gives L=3. Throughput is 1 sample per enabled clock; back-to-back samples give back-to-back results.
- ce=0: no register changes, including valid bits and outputs. out_valid holds its value, so consumers must qualify it with ce. Stalled cycles do not count toward latency.
- in_valid=0 with ce=1: a bubble propagates. out_valid=0 in the matching output cycle; out_value, out_index, out_second and out_dominant hold.
- out_second and out_dominant update on every valid result.
- out_value and out_index:
  - HOLD_ON_AMBIG=1: update only when the result is dominant; otherwise they keep the last dominant result (reset value if none yet).
  - HOLD_ON_AMBIG=0: update on every valid result.
- All-equal inputs: index 0, second = max, diff 0, so not dominant for any MARGIN >= 0.
- All-zero inputs: value 0, index 0, not dominant.
- MARGIN >= 2^W - 1: never dominant. This is legal and needs no special handling.

Test Plan:
- Reset: drive random in_data with in_valid=1, hold rst_n=0 -> all outputs 0. Assert rst_n=0 one cycle after a sample enters -> no out_valid after release until a new sample has completed L cycles.
- N=3, W=10, MARGIN=0: in (R,G,B)=(500,200,100) -> 3 cycles later out_valid=1, value=500, index=0, second=200, dominant=1. Then (100,700,699) -> value=700, index=1, second=699, dominant=1.
- Tie, HOLD_ON_AMBIG=1: (500,200,100) then (300,300,100) -> second result has out_second=300, dominant=0, value/index stay 500/0. Repeat with HOLD_ON_AMBIG=0 -> value=300, index=0.
- Throughput/stall: 4 back-to-back samples with ce toggling 1,0,1,1,0,1... -> results appear in order, one per enabled cycle. Outputs frozen while ce=0. Latency counted in enabled edges only.
- MARGIN=16: (520,510,0) -> dominant=0. (530,510,0) -> dominant=1 (diff 20). (526,510,0) -> dominant=0 (diff 16, not > 16).
- N=8, W=8: one-hot max sweep (channel k=255, others k) for k=0..7 -> index=k, value=255. Then all channels=42 -> index=0, second=42, dominant=0.
